// File: rtl/id_stage.sv
// Instruction-decode stage: holds the fetched instruction in the ID register,
// slices out its fields, builds the sign-extended immediate and detects
// load-use hazards against the instruction currently in EX.
//
// Pipeline control semantics:
//   stall        : combinational. While high, fetch holds its PC and the ID
//                  register keeps its contents. It stays high only as long as
//                  the hazard holds, with no extra hold cycles added.
//   branch_taken : flush request. It overrides stall and loads a NOP bubble.
//   id_bubble    : tells EX to take a bubble this cycle (stall or empty ID).
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] if_pc,
  input  logic [31:0] if_instruction,
  input  logic        branch_taken,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rd,
  output logic        stall,
  output logic        id_valid,
  output logic [63:0] id_pc,
  output logic [31:0] id_instruction,
  output logic [6:0]  id_opcode,
  output logic [4:0]  id_rd,
  output logic [2:0]  id_funct3,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [6:0]  id_funct7,
  output logic [63:0] id_imm,
  output logic        id_bubble,
  output logic [15:0] stall_count
);

  localparam logic [31:0] NOP = 32'h00000013;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic rs1_used;
  logic rs2_used;

  // Field slices of the registered instruction word.
  assign id_opcode = id_instruction[6:0];
  assign id_rd     = id_instruction[11:7];
  assign id_funct3 = id_instruction[14:12];
  assign id_rs1    = id_instruction[19:15];
  assign id_rs2    = id_instruction[24:20];
  assign id_funct7 = id_instruction[31:25];

  // Which source registers the decoded opcode actually reads.
  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (id_opcode)
      OP_REG, OP_REG32, OP_STORE, OP_BRANCH: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_IMM, OP_IMM32, OP_LOAD, OP_JALR: rs1_used = 1'b1;
      default: ;
    endcase
  end

  // Load-use hazard: EX holds a load whose non-x0 destination we read.
  assign stall = id_valid && idex_mem_read && (idex_rd != 5'd0) &&
                 ((rs1_used && (idex_rd == id_rs1)) ||
                  (rs2_used && (idex_rd == id_rs2)));

  assign id_bubble = stall || !id_valid;

  // Sign-extended immediate chosen by instruction format.
  always_comb begin
    id_imm = 64'd0;
    case (id_opcode)
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR:
        id_imm = {{52{id_instruction[31]}}, id_instruction[31:20]};
      OP_STORE:
        id_imm = {{52{id_instruction[31]}}, id_instruction[31:25],
                  id_instruction[11:7]};
      OP_BRANCH:
        id_imm = {{51{id_instruction[31]}}, id_instruction[31],
                  id_instruction[7], id_instruction[30:25],
                  id_instruction[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        id_imm = {{32{id_instruction[31]}}, id_instruction[31:12], 12'd0};
      OP_JAL:
        id_imm = {{43{id_instruction[31]}}, id_instruction[31],
                  id_instruction[19:12], id_instruction[20],
                  id_instruction[30:21], 1'b0};
      default: id_imm = 64'd0;
    endcase
  end

  // ID register: reset > flush > hold on stall > load from fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid       <= 1'b0;
      id_pc          <= 64'd0;
      id_instruction <= NOP;
    end else if (branch_taken) begin
      id_valid       <= 1'b0;
      id_pc          <= 64'd0;
      id_instruction <= NOP;
    end else if (!stall) begin
      id_valid       <= 1'b1;
      id_pc          <= if_pc;
      id_instruction <= if_instruction;
    end
  end

  // Saturating count of stalled cycles since reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= 16'd0;
    end else if (stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule
